// File: rtl/sipo_rx_pkg.sv
// Shared types and helpers for the serial-in/parallel-out frame receiver.
package sipo_rx_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 3;
  localparam int MAX_W     = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

  // cur must be zero above 'width'; callers truncate the result back to 'width' bits.
  function automatic logic [MAX_W-1:0] shift_next(input logic [MAX_W-1:0] cur,
                                                  input logic si,
                                                  input int width,
                                                  input logic msb_first);
    logic [MAX_W-1:0] res;
    logic [5:0]       top;
    top = 6'(width - 1);
    if (msb_first) begin
      res = {cur[MAX_W-2:0], si};
    end else begin
      res      = cur >> 1;
      res[top] = si;
    end
    return res;
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// WIDTH-bit shift register; clr with shift_en restarts the word at the current bit.
module sipo_shift_core
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             si,
  output logic [WIDTH-1:0] core,
  output logic [WIDTH-1:0] next_word
);

  logic [WIDTH-1:0] core_q;
  logic [WIDTH-1:0] core_d;
  logic [WIDTH-1:0] base;

  always_comb begin
    base      = clr ? '0 : core_q;
    next_word = WIDTH'(shift_next(MAX_W'(core_q), si, WIDTH, MSB_FIRST));
    core_d    = core_q;
    if (shift_en) begin
      core_d = WIDTH'(shift_next(MAX_W'(base), si, WIDTH, MSB_FIRST));
    end else if (clr) begin
      core_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_q <= '0;
    end else begin
      core_q <= core_d;
    end
  end

  assign core = core_q;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Frame controller: SOF-qualified bit counting, word capture with valid/ready, sticky OVF/FERR.
// Handshake: a word in DOUT is consumed at a rising edge where DVALID and DREADY are both high.
module sipo_rx_ctrl
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic             SI,
  input  logic             SOF,
  input  logic             DREADY,
  input  logic             CLR_FLG,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID,
  output logic             BUSY,
  output logic             OVF,
  output logic             FERR
);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             ovf_q, ovf_d;
  logic             ferr_q, ferr_d;

  logic             shift_en, core_clr, complete, ferr_set, ovf_set;
  logic [WIDTH-1:0] core_word, next_word;

  sipo_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .clk      (C),
    .rst_n    (CLR_N),
    .shift_en (shift_en),
    .clr      (core_clr),
    .si       (SI),
    .core     (core_word),
    .next_word(next_word)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    core_clr = 1'b0;
    complete = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (SOF) begin
          shift_en = 1'b1;
          core_clr = 1'b1;
          cnt_d    = FIRST_CNT;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (SOF) begin
          // Resync wins even on the last-bit edge: the old frame never completes.
          shift_en = 1'b1;
          core_clr = 1'b1;
          ferr_set = 1'b1;
          cnt_d    = FIRST_CNT;
        end else if (cnt_q == LAST_CNT) begin
          complete = 1'b1;
          core_clr = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + FIRST_CNT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    ovf_set  = 1'b0;
    if (complete) begin
      if (!dvalid_q || DREADY) begin
        dout_d   = next_word;
        dvalid_d = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (dvalid_q && DREADY) begin
      dvalid_d = 1'b0;
    end
    ovf_d  = ovf_set  | (ovf_q  & ~CLR_FLG);
    ferr_d = ferr_set | (ferr_q & ~CLR_FLG);
  end

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
    end
  end

  // The core is cleared on completion, so it must be empty whenever the FSM is idle.
  assert property (@(posedge C) disable iff (!CLR_N) (state_q == IDLE) |-> (core_word == '0));

  assign DOUT   = dout_q;
  assign DVALID = dvalid_q;
  assign BUSY   = (state_q == SHIFT);
  assign OVF    = ovf_q;
  assign FERR   = ferr_q;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Bench for sipo_rx_ctrl: MSB-first and LSB-first instances fed the same serial stream.
module tb_sipo_rx_ctrl;

  logic       c = 1'b0;
  logic       clr_n, si, sof, dready, clr_flg;
  logic [7:0] dout_m, dout_l;
  logic       dvalid_m, busy_m, ovf_m, ferr_m;
  logic       dvalid_l, busy_l, ovf_l, ferr_l;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_l_q[$];

  logic last_v_m = 1'b0, last_acc_m = 1'b0;
  logic last_v_l = 1'b0, last_acc_l = 1'b0;

  typedef struct {
    logic [7:0] word;
    int         rdy_mode;
    bit         push;
    bit         clr_after;
    int         gap;
    logic [7:0] exp_dout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[5];

  sipo_rx_ctrl #(.WIDTH(8), .CNT_W(3), .MSB_FIRST(1'b1)) dut_m (
    .C(c), .CLR_N(clr_n), .SI(si), .SOF(sof), .DREADY(dready), .CLR_FLG(clr_flg),
    .DOUT(dout_m), .DVALID(dvalid_m), .BUSY(busy_m), .OVF(ovf_m), .FERR(ferr_m)
  );

  sipo_rx_ctrl #(.WIDTH(8), .CNT_W(3), .MSB_FIRST(1'b0)) dut_l (
    .C(c), .CLR_N(clr_n), .SI(si), .SOF(sof), .DREADY(dready), .CLR_FLG(clr_flg),
    .DOUT(dout_l), .DVALID(dvalid_l), .BUSY(busy_l), .OVF(ovf_l), .FERR(ferr_l)
  );

  // clock / reset
  always #5 c = ~c;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // driver tasks: inputs change 1ns after the rising edge
  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic idle(input int n);
    sof = 1'b0;
    si  = 1'b0;
    repeat (n) tick();
  endtask

  // rdy_mode: 0 = DREADY low, 1 = DREADY high, 2 = DREADY high only on the last-bit edge
  task automatic send_frame(input logic [7:0] w, input int rdy_mode, input bit push);
    if (push) begin
      exp_q.push_back(w);
      exp_l_q.push_back(rev8(w));
    end
    for (int i = 0; i < 8; i++) begin
      si     = w[7-i];
      sof    = (i == 0);
      dready = (rdy_mode == 1) || (rdy_mode == 2 && i == 7);
      tick();
    end
    sof    = 1'b0;
    si     = 1'b0;
    dready = (rdy_mode == 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dout"},   dout_m,   8'h00);
    check({tag, "_dvalid"}, {7'b0, dvalid_m}, 8'h00);
    check({tag, "_busy"},   {7'b0, busy_m},   8'h00);
    check({tag, "_ovf"},    {7'b0, ovf_m},    8'h00);
    check({tag, "_ferr"},   {7'b0, ferr_m},   8'h00);
  endtask

  // scoreboard: a word is new when DVALID rises or stays high across an accepting edge
  initial begin
    forever begin
      @(negedge c);
      if (dvalid_m && (!last_v_m || last_acc_m)) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL sb_msb: got word %0h expected no word", dout_m);
        end else begin
          check("sb_msb_word", dout_m, exp_q.pop_front());
        end
      end
      if (dvalid_l && (!last_v_l || last_acc_l)) begin
        if (exp_l_q.size() == 0) begin
          total_cnt++;
          $display("FAIL sb_lsb: got word %0h expected no word", dout_l);
        end else begin
          check("sb_lsb_word", dout_l, exp_l_q.pop_front());
        end
      end
      last_v_m   = dvalid_m;
      last_acc_m = dvalid_m && dready;
      last_v_l   = dvalid_l;
      last_acc_l = dvalid_l && dready;
    end
  end

  initial begin
    vecs[0] = '{8'hDC, 1, 1'b1, 1'b0, 0, 8'hDC, 1'b0};
    vecs[1] = '{8'h33, 1, 1'b1, 1'b0, 2, 8'h33, 1'b0};
    vecs[2] = '{8'hDC, 0, 1'b1, 1'b0, 0, 8'hDC, 1'b0};
    vecs[3] = '{8'hA5, 0, 1'b0, 1'b1, 0, 8'hDC, 1'b1};
    vecs[4] = '{8'hA5, 2, 1'b1, 1'b0, 0, 8'hA5, 1'b0};

    clr_n = 1'b0; si = 1'b0; sof = 1'b0; dready = 1'b0; clr_flg = 1'b0;
    repeat (2) @(posedge c);
    #1;
    check_outputs_zero("reset");
    clr_n = 1'b1;
    tick();

    // reset in the middle of a frame
    for (int i = 0; i < 3; i++) begin
      si  = 1'b1;
      sof = (i == 0);
      tick();
    end
    sof = 1'b0;
    check("partial_busy", {7'b0, busy_m}, 8'h01);
    clr_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(posedge c);
    #1;
    clr_n = 1'b1;

    // single frame held, then consumed
    send_frame(8'hDC, 0, 1'b1);
    check("single_dout",   dout_m, 8'hDC);
    check("single_dout_l", dout_l, 8'h3B);
    check("single_dvalid", {7'b0, dvalid_m}, 8'h01);
    check("single_busy",   {7'b0, busy_m},   8'h00);
    dready = 1'b1;
    tick();
    dready = 1'b0;
    check("consume_dvalid", {7'b0, dvalid_m}, 8'h00);
    check("consume_dout",   dout_m, 8'hDC);

    // table: back-to-back, overflow, flag clear, completion on an accepting edge
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].word, vecs[v].rdy_mode, vecs[v].push);
      check($sformatf("vec%0d_dout", v),   dout_m, vecs[v].exp_dout);
      check($sformatf("vec%0d_dout_l", v), dout_l, rev8(vecs[v].exp_dout));
      check($sformatf("vec%0d_dvalid", v), {7'b0, dvalid_m}, 8'h01);
      check($sformatf("vec%0d_busy", v),   {7'b0, busy_m},   8'h00);
      check($sformatf("vec%0d_ovf", v),    {7'b0, ovf_m},    {7'b0, vecs[v].exp_ovf});
      if (vecs[v].clr_after) begin
        clr_flg = 1'b1;
        tick();
        clr_flg = 1'b0;
        check($sformatf("vec%0d_ovf_clr", v), {7'b0, ovf_m}, 8'h00);
        check($sformatf("vec%0d_hold", v),    dout_m, vecs[v].exp_dout);
      end
      idle(vecs[v].gap);
    end
    dready = 1'b1;
    tick();
    dready = 1'b0;
    check("drain_dvalid", {7'b0, dvalid_m}, 8'h00);

    // mid-frame resync
    dready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      si  = 1'b1;
      sof = (i == 0);
      tick();
    end
    check("pre_resync_ferr", {7'b0, ferr_m}, 8'h00);
    check("pre_resync_busy", {7'b0, busy_m}, 8'h01);
    exp_q.push_back(8'hA5);
    exp_l_q.push_back(rev8(8'hA5));
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w   = 8'hA5;
      si  = w[7-i];
      sof = (i == 0);
      tick();
      if (i == 0) begin
        check("resync_ferr", {7'b0, ferr_m}, 8'h01);
        check("resync_busy", {7'b0, busy_m}, 8'h01);
      end
      if (i == 6) check("resync_early_dvalid", {7'b0, dvalid_m}, 8'h00);
    end
    sof = 1'b0;
    check("resync_dout",   dout_m, 8'hA5);
    check("resync_dout_l", dout_l, 8'hA5);
    check("resync_dvalid", {7'b0, dvalid_m}, 8'h01);
    idle(1);

    // SOF on the last-bit edge, with CLR_FLG in the same cycle (set wins)
    for (int i = 0; i < 7; i++) begin
      si  = i[0];
      sof = (i == 0);
      tick();
    end
    exp_q.push_back(8'h33);
    exp_l_q.push_back(rev8(8'h33));
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w       = 8'h33;
      si      = w[7-i];
      sof     = (i == 0);
      clr_flg = (i == 0);
      tick();
      if (i == 0) begin
        check("lastbit_ferr",   {7'b0, ferr_m},   8'h01);
        check("lastbit_dvalid", {7'b0, dvalid_m}, 8'h00);
      end
    end
    clr_flg = 1'b0;
    sof     = 1'b0;
    check("lastbit_dout",   dout_m, 8'h33);
    check("lastbit_dout_l", dout_l, 8'hCC);
    idle(1);
    clr_flg = 1'b1;
    tick();
    clr_flg = 1'b0;
    check("ferr_clr", {7'b0, ferr_m}, 8'h00);
    check("lsb_ferr_clr", {7'b0, ferr_l}, 8'h00);

    dready = 1'b0;
    idle(2);
    check("sb_msb_empty", 8'(exp_q.size()),   8'h00);
    check("sb_lsb_empty", 8'(exp_l_q.size()), 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
